// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives imem_addr and buffers fetched words in a prefetch FIFO for decode.
// Optional stall/flush counters are built when FETCH_PERF_CNT_EN is defined.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  localparam int unsigned   AW      = $clog2(DEPTH);
  localparam int unsigned   CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];
  logic          push_s, pop_s, full_s, empty_s;

  // Push depends only on registered occupancy, so out_ready never reaches imem_addr.
  always_comb begin
    full_s  = (count_q == DEPTH_C);
    empty_s = (count_q == {CW{1'b0}});
    push_s  = (state_q == RUN) && fetch_en && !redirect && !full_s;
    pop_s   = !empty_s && out_ready && !redirect;
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    case (state_q)
      IDLE:    if (fetch_en) state_d = RUN;  else state_d = IDLE;
      RUN:     if (fetch_en) state_d = RUN;  else state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (redirect) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      wr_ptr_d   = {AW{1'b0}};
      rd_ptr_d   = {AW{1'b0}};
      count_d    = {CW{1'b0}};
    end else begin
      if (push_s) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = wr_ptr_q + AW'(1);
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (pop_s) rd_ptr_d = rd_ptr_q + AW'(1);
      else       rd_ptr_d = rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk) begin
    if (push_s) begin
      instr_mem_q[wr_ptr_q] <= imem_instr;
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
    end
  end

  assign imem_addr = fetch_pc_q;

  always_comb begin
    out_valid = !empty_s;
    if (!empty_s) begin
      out_instr = instr_mem_q[rd_ptr_q];
      out_pc    = pc_mem_q[rd_ptr_q];
    end else begin
      out_instr = NOP;
      out_pc    = 32'h0000_0000;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    if ((state_q == RUN) && fetch_en && full_s && !redirect) stall_cycles_d = stall_cycles_q + 32'd1;
    else                                                     stall_cycles_d = stall_cycles_q;
    if (redirect) flush_count_d = flush_count_q + 32'd1;
    else          flush_count_d = flush_count_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= 32'h0000_0000;
      flush_count_q  <= 32'h0000_0000;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, async reset check, then random traffic vs a queue model.
module tb_instr_fetch_unit;
  localparam int unsigned DEPTH = 4;

  logic        clk, reset, fetch_en, redirect, out_valid, out_ready;
  logic [31:0] imem_addr, imem_instr, redirect_pc, out_instr, out_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  int checks   = 0;
  int failures = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
`ifdef FETCH_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: addi x(k+1), x0, k at word k.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    logic [31:0] k;
    k = a >> 2;
    return ((k & 32'h0000_0FFF) << 20) | (((k + 32'd1) & 32'h0000_001F) << 7) | 32'h0000_0013;
  endfunction

  assign imem_instr = instr_of(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic ev, input logic [31:0] epc, input logic [31:0] eaddr);
    chk({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, ev});
    chk({tag, " out_pc"}, out_pc, ev ? epc : 32'h0000_0000);
    chk({tag, " out_instr"}, out_instr, ev ? instr_of(epc) : 32'h0000_0013);
    chk({tag, " imem_addr"}, imem_addr, eaddr);
  endtask

  typedef struct {
    logic        fe;
    logic        rdy;
    logic        rdir;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
  } vec_t;

  vec_t tbl[$];

  // Reference model: queue of buffered PCs plus the fetch PC and run flag.
  logic [31:0] mq[$];
  logic [31:0] mpc;
  bit          mrun;
  logic [31:0] mstall, mflush;

  task automatic model_reset();
    mq.delete();
    mpc    = 32'h0000_0000;
    mrun   = 1'b0;
    mstall = 32'h0;
    mflush = 32'h0;
  endtask

  task automatic model_step(input logic fe, input logic rdy, input logic rdir, input logic [31:0] rpc);
    int sz;
    sz = mq.size();
    if (rdir) begin
      mq.delete();
      mpc = rpc & 32'hFFFF_FFFC;
      mflush = mflush + 32'd1;
    end else begin
      if (mrun && fe && sz == DEPTH) mstall = mstall + 32'd1;
      if (sz > 0 && rdy) void'(mq.pop_front());
      if (mrun && fe && sz < DEPTH) begin
        mq.push_back(mpc);
        mpc = mpc + 32'd4;
      end
    end
    mrun = fe;
  endtask

  initial begin
    logic        fe, rdy, rdir;
    logic [31:0] rpc;

    // cycle-by-cycle directed vectors: backpressure, drain, redirect, redirect-while-full with wrap, fetch_en hold
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h4});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h8});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'hC});
    for (int i = 0; i < 5; i++) tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h10});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 32'h10});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4, 32'h10});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h8, 32'h14});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hC, 32'h18});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h10, 32'h1C});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 32'h0000_0102, 1'b1, 32'h14, 32'h20});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h100});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 32'h104});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 32'h108});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 32'h10C});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, 32'h100, 32'h110});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'hFFFF_FFF8});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h4});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h4});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h4});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h8});

    reset = 1'b1; fetch_en = 1'b0; out_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_outputs("reset", 1'b0, 32'h0, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      fetch_en = tbl[i].fe; out_ready = tbl[i].rdy; redirect = tbl[i].rdir; redirect_pc = tbl[i].rpc;
      #1;
      chk_outputs($sformatf("vec%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].eaddr);
      @(posedge clk);
      @(negedge clk);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("stall_cycles table", stall_cycles, 32'd6);
    chk("flush_count table", flush_count, 32'd2);
`endif

    // asynchronous reset between edges while the head is valid
    #2 reset = 1'b1;
    #1;
    chk_outputs("async_reset", 1'b0, 32'h0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("stall_cycles reset", stall_cycles, 32'd0);
`endif
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    for (int c = 0; c < 600; c++) begin
      fe   = ($urandom % 8) != 0;
      rdy  = ($urandom % 3) != 0;
      rdir = ($urandom % 16) == 0;
      if (($urandom % 4) == 0) rpc = 32'hFFFF_FFF0 | ($urandom % 16);
      else                     rpc = $urandom;
      if (c < 4) begin
        fe = 1'b1; rdy = 1'b1; rdir = 1'b0;
      end
      fetch_en = fe; out_ready = rdy; redirect = rdir; redirect_pc = rpc;
      #1;
      if (mq.size() > 0) chk_outputs($sformatf("rnd%0d", c), 1'b1, mq[0], mpc);
      else               chk_outputs($sformatf("rnd%0d", c), 1'b0, 32'h0, mpc);
      @(posedge clk);
      model_step(fe, rdy, rdir, rpc);
      @(negedge clk);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("stall_cycles rnd", stall_cycles, mstall);
    chk("flush_count rnd", flush_count, mflush);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage that owns the program counter, drives the combinational instruction memory address and buffers fetched words in a small prefetch FIFO. It hands the words to the CPU decode stage over a valid/ready handshake. Branch and jump redirects from execute flush the FIFO and restart fetch at the target. It sits between instr_mem and the decode input of cpu.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
DEPTH, 4, prefetch FIFO entries; power of two, 2..16.

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  asynchronous, active-high reset
fetch_en  input  1  enables fetching; low holds the PC and stops pushes
imem_addr  output  32  address to instr_mem; equals the fetch PC
imem_instr  input  32  instruction word from instr_mem, valid in the same cycle
redirect  input  1  flush the FIFO and restart fetch at redirect_pc
redirect_pc  input  32  redirect target; bits [1:0] are ignored and forced to 0
out_valid  output  1  FIFO head holds a valid instruction
out_ready  input  1  decode accepts the head this cycle
out_instr  output  32  head instruction; 32'h0000_0013 (NOP) when out_valid=0
out_pc  output  32  PC of the head instruction; 0 when out_valid=0

Behaviour:
- Reset (asynchronous, any cycle):
  - fetch_pc=RESET_PC, FIFO empty (count=0, pointers 0), FSM=IDLE.
  - Outputs: out_valid=0, out_instr=32'h13, out_pc=0, imem_addr=RESET_PC.
- FSM, 2 states:
  - IDLE: no pushes. Moves to RUN on the edge where fetch_en=1.
  - RUN: moves to IDLE on the edge where fetch_en=0 (FIFO contents kept). A redirect is honoured in either state.
- Push condition: state==RUN && fetch_en && !redirect && count<DEPTH.
  - Uses only registered count. No combinational path from out_ready to imem_addr.
  - On push: write {imem_instr, fetch_pc} at the write pointer, then fetch_pc += 4.
  - 32-bit wrap: 32'hFFFF_FFFC + 4 = 0.
- Pop condition: out_valid && out_ready. Advances the read pointer.
- Push and pop in the same cycle: count unchanged, both pointers advance modulo DEPTH.
- Full (count==DEPTH): no push, fetch_pc holds, even if a pop happens that cycle. Fetch resumes the following cycle.
- Empty: out_valid=0. A pop request is ignored.
- Latency: a word pushed at edge N is presented with out_valid=1 in the cycle after edge N. There is no bypass from imem to the output.
- Redirect has priority over push and pop:
  - At the edge: FIFO cleared (count=0), fetch_pc <= {redirect_pc[31:2],2'b00}. No push and no pop take effect that cycle.
  - out_valid=0 in the cycle after the redirect.
  - The target instruction appears with out_valid=1 two cycles after redirect is sampled, provided fetch_en=1 and state is RUN.
- Back-to-back redirects: the last one wins. Each resets the two-cycle latency.
- imem_addr = fetch_pc at all times.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined: adds output ports stall_cycles[31:0] and flush_count[31:0], both reset to 0 and wrapping on overflow.
  - stall_cycles increments on every cycle with state==RUN && fetch_en && count==DEPTH && !redirect.
  - flush_count increments on every sampled redirect.
- Undefined: both ports and their counters are absent. All other behaviour is identical.

Test Plan:
1. Sequential fetch: reset, fetch_en=1, out_ready=1, imem holds 0x00000093, 0x00100113, ... at 0x0, 0x4, ... -> out_valid first rises 2 cycles after reset deassertion; out_pc runs 0x0, 0x4, 0x8 with matching words, one per cycle, with no gaps.
2. Backpressure, DEPTH=4: out_ready=0 for 10 cycles -> count saturates at 4, imem_addr holds 0x10, head stays pc=0x0. Then out_ready=1 -> pcs 0x0..0x10 delivered in order, with no loss and no duplicates. With FETCH_PERF_CNT_EN, stall_cycles shows the full-cycle count (6 cycles after fill).
3. Redirect: with the FIFO partly full, redirect=1, redirect_pc=0x0000_0102 -> next cycle out_valid=0, imem_addr=0x100. Two cycles after the redirect, out_valid=1 with out_pc=0x100. flush_count=1.
4. Redirect while full with out_ready=1 in the same cycle: no pop occurs, FIFO empties, and the old head is never delivered again.
5. Wrap: redirect_pc=0xFFFF_FFF8 -> out_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
6. Asynchronous reset mid-run: assert reset between clock edges while out_valid=1 -> outputs return to reset values immediately (out_valid=0, out_instr=0x13). After release, fetch restarts at RESET_PC.
